// File: rtl/score_frame_loader.sv
// score_frame_loader
//   Gathers ten serial class scores (beat k = class k) into a collection
//   bank. A complete frame is presented on image_number_0..9 from a separate
//   output bank, so the next frame can fill while the current one is held
//   for the max selector.
//
//   Optional feature macro: LAST_CHECK_EN. When it is defined, in_last is
//   checked against the beat count and malformed frames are dropped with a
//   frame_err pulse. When it is undefined, in_last is ignored and frame_err
//   is tied 0.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     score beat handshake
//   in_score              class score, SCORE_W bits
//   in_last               beat-9 marker (LAST_CHECK_EN only)
//   image_number_0..9     held output-bank scores
//   out_valid/out_ack     output frame handshake
//   frame_err             one-cycle pulse on a discarded frame
module score_frame_loader #(
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_last,
  output logic [SCORE_W-1:0] image_number_0,
  output logic [SCORE_W-1:0] image_number_1,
  output logic [SCORE_W-1:0] image_number_2,
  output logic [SCORE_W-1:0] image_number_3,
  output logic [SCORE_W-1:0] image_number_4,
  output logic [SCORE_W-1:0] image_number_5,
  output logic [SCORE_W-1:0] image_number_6,
  output logic [SCORE_W-1:0] image_number_7,
  output logic [SCORE_W-1:0] image_number_8,
  output logic [SCORE_W-1:0] image_number_9,
  output logic               out_valid,
  input  logic               out_ack,
  output logic               frame_err
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [9:0][SCORE_W-1:0]   coll_q, coll_d;
  logic [9:0][SCORE_W-1:0]   out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      err_q, err_d;

  logic accept, ack, last9, bad_last, slot_free, xfer_in, xfer_hold;

  assign accept    = in_valid & in_ready;
  assign ack       = out_ack & out_valid_q;   // ack without a frame is ignored
  assign last9     = (cnt_q == 4'd9);
  // An ack in the same cycle frees the slot, so the new frame lands with no gap.
  assign slot_free = ~out_valid_q | out_ack;

`ifdef LAST_CHECK_EN
  assign bad_last = accept & (in_last != last9);
`else
  logic unused_last;
  assign unused_last = in_last;
  assign bad_last    = 1'b0;
`endif

  assign xfer_in   = (state_q == FILL) & accept & last9 & ~bad_last & slot_free;
  assign xfer_hold = (state_q == HOLD) & ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (accept & last9 & ~bad_last & ~slot_free) state_d = HOLD;
      HOLD: if (ack) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs: in_ready depends only on state and rst
  always_comb begin
    in_ready = ~rst & (state_q == FILL);
  end

  // Datapath next state
  always_comb begin
    cnt_d       = cnt_q;
    coll_d      = coll_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    if (bad_last) begin
      cnt_d = 4'd0;
      err_d = 1'b1;
    end else if ((state_q == FILL) && accept) begin
      coll_d[cnt_q] = in_score;
      if (!last9) begin
        cnt_d = cnt_q + 4'd1;
      end else if (slot_free) begin
        // Entries 0..8 come from the bank, class 9 straight from the input.
        out_d    = coll_q;
        out_d[9] = in_score;
        cnt_d    = 4'd0;
      end
    end
    if (xfer_hold) begin
      out_d = coll_q;
      cnt_d = 4'd0;
    end
    if (xfer_in | xfer_hold) out_valid_d = 1'b1;
    else if (ack)            out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      coll_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      coll_q      <= coll_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign frame_err      = err_q;
  assign image_number_0 = out_q[0];
  assign image_number_1 = out_q[1];
  assign image_number_2 = out_q[2];
  assign image_number_3 = out_q[3];
  assign image_number_4 = out_q[4];
  assign image_number_5 = out_q[5];
  assign image_number_6 = out_q[6];
  assign image_number_7 = out_q[7];
  assign image_number_8 = out_q[8];
  assign image_number_9 = out_q[9];

endmodule

// File: tb/tb_score_frame_loader.sv
// Testbench for score_frame_loader. A frame-level model (a queue of pending
// beats plus the expected held frame) predicts in_ready, out_valid,
// frame_err and the ten scores on every cycle.
module tb_score_frame_loader;
  localparam int W = 16;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ack = 1'b0;
  logic [W-1:0] in_score = '0;
  logic in_ready, out_valid, frame_err;
  logic [W-1:0] n0, n1, n2, n3, n4, n5, n6, n7, n8, n9;
  logic [W-1:0] img [10];

  int checks = 0, errors = 0;
  logic [W-1:0] pend [$];
  logic [W-1:0] exp_out [10];
  logic [W-1:0] fr [10];
  logic exp_vld, exp_err;

  always #5 clk = ~clk;
  always_comb img = '{n0, n1, n2, n3, n4, n5, n6, n7, n8, n9};

  score_frame_loader #(.SCORE_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_last(in_last),
    .image_number_0(n0), .image_number_1(n1), .image_number_2(n2),
    .image_number_3(n3), .image_number_4(n4), .image_number_5(n5),
    .image_number_6(n6), .image_number_7(n7), .image_number_8(n8),
    .image_number_9(n9),
    .out_valid(out_valid), .out_ack(out_ack), .frame_err(frame_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic r, input logic v, input logic [W-1:0] s,
                      input logic l, input logic a);
    logic rdy, acc, ack, xfer;
    rst = r; in_valid = v; in_score = s; in_last = l; out_ack = a;
    #1;
    rdy = !r && (pend.size() < 10);
    chk1("in_ready", in_ready, rdy);
    exp_err = 1'b0; xfer = 1'b0;
    acc = v && rdy;
    ack = a && exp_vld;
    if (r) begin
      pend.delete();
      exp_vld = 1'b0;
      foreach (exp_out[i]) exp_out[i] = '0;
    end else begin
      if (pend.size() == 10) begin
        if (ack) xfer = 1'b1;
      end else if (acc) begin
        pend.push_back(s);
`ifdef LAST_CHECK_EN
        if (l != (pend.size() == 10)) begin
          pend.delete();
          exp_err = 1'b1;
        end
`endif
        if (pend.size() == 10 && (!exp_vld || ack)) xfer = 1'b1;
      end
      if (xfer) begin
        for (int i = 0; i < 10; i++) exp_out[i] = pend[i];
        pend.delete();
        exp_vld = 1'b1;
      end else if (ack) begin
        exp_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk1("out_valid", out_valid, exp_vld);
    chk1("frame_err", frame_err, exp_err);
    for (int i = 0; i < 10; i++) chkw($sformatf("image_number_%0d", i), img[i], exp_out[i]);
  endtask

  // Send beats 0..nb-1 of fr; in_last on beat lastpos; out_ack on beat 9 if ack9.
  task automatic send(input int nb, input int lastpos, input logic ack9);
    for (int k = 0; k < nb; k++)
      step(1'b0, 1'b1, fr[k], (k == lastpos), ack9 && (k == 9));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 10; k++) fr[k] = W'($urandom);
  endtask

  initial begin
    logic l, v, a, r;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    foreach (exp_out[i]) exp_out[i] = '0;

    // Reset with in_valid high: in_ready must stay low
    step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Frame A = 1..10, no ack, then held stable for 20 cycles
    for (int k = 0; k < 10; k++) fr[k] = W'(k + 1);
    send(10, 9, 1'b0);
    repeat (20) step(1'b0, 1'b0, W'($urandom), 1'b0, 1'b0);

    // Backpressure: frame B while A is held -> HOLD, then ack shows B
    rand_frame(); fr[5] = 16'd14;
    send(10, 9, 1'b0);
    repeat (3) step(1'b0, 1'b1, W'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Frame C with ack on beat 9: replaces B without an out_valid gap
    rand_frame(); fr[1] = 16'd13; fr[9] = 16'd0;
    send(10, 9, 1'b1);

    // Reset after beat 4, then one clean frame
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    rand_frame();
    send(10, 9, 1'b1);

`ifdef LAST_CHECK_EN
    // Early in_last on beat 6 with an empty output slot
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    rand_frame();
    send(7, 6, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rand_frame();
    send(10, 9, 1'b0);
    // Missing in_last on beat 9: held bank untouched, next frame from cnt 0
    rand_frame();
    send(10, -1, 1'b0);
    rand_frame();
    send(10, 9, 1'b1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(3) != 0);
      a = ($urandom_range(2) == 0);
      r = ($urandom_range(96) == 0);
`ifdef LAST_CHECK_EN
      l = (pend.size() == 9) ^ ($urandom_range(19) == 0);
`else
      l = 1'($urandom);
`endif
      step(r, v, W'($urandom), l, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
